// File: rtl/rv_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : rv_ram_responder
// Description : Data-memory responder for the single-cycle core. Serves
//               ram_load/ram_store from an internal word RAM and an MMIO page
//               holding a buffered console transmitter (CONSOLE_DATA,
//               CONSOLE_STATUS) and, when RV_RAM_RESPONDER_CYCLE_EN is
//               defined, a free-running 64-bit cycle counter
//               (CYCLE_LO/CYCLE_HI).
// Revision    : 1.0 - initial release
// ============================================================================
module rv_ram_responder #(
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ram_load,
    input  logic        ram_store,
    input  logic [2:0]  ram_funct3,
    input  logic [29:0] ram_address,
    input  logic [31:0] ram_store_value,
    output logic [31:0] ram_load_value,
    output logic        efault,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    // Word addresses of the MMIO registers (byte address >> 2)
    localparam logic [29:0] c_ADDR_DATA = 30'h3FFF_FFC0;  // 0xFFFF_FF00
    localparam logic [29:0] c_ADDR_STAT = 30'h3FFF_FFC1;  // 0xFFFF_FF04
    localparam logic [29:0] c_ADDR_CLO  = 30'h3FFF_FFC2;  // 0xFFFF_FF08
    localparam logic [29:0] c_ADDR_CHI  = 30'h3FFF_FFC3;  // 0xFFFF_FF0C
    localparam logic [PW:0] c_FULL_CNT  = (PW+1)'(FIFO_DEPTH);

    logic [31:0]   r_ram  [DEPTH];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          r_ovf;

    logic          w_is_ram;
    logic          w_is_data;
    logic          w_is_stat;
    logic          w_is_clo;
    logic          w_is_chi;
    logic          w_mapped;
    logic          w_efault;
    logic          w_ld_ok;
    logic          w_st_ok;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_push_ok;
    logic [3:0]    w_cnt4;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic [63:0]   w_cycle;

    // Width/sign handling is done inside the core; funct3 is intentionally unused
    logic          w_unused;
    assign w_unused = ^ram_funct3;

    // Address decode
    assign w_is_ram  = (ram_address[29:AW] == '0);
    assign w_is_data = (ram_address == c_ADDR_DATA);
    assign w_is_stat = (ram_address == c_ADDR_STAT);

`ifdef RV_RAM_RESPONDER_CYCLE_EN
    logic [63:0] r_cycle;

    // Free-running cycle counter, wraps naturally at 2^64
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle <= 64'd0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
        end
    end

    assign w_cycle  = r_cycle;
    assign w_is_clo = (ram_address == c_ADDR_CLO);
    assign w_is_chi = (ram_address == c_ADDR_CHI);
`else
    // Counter not built: its addresses fall through to unmapped
    assign w_cycle  = 64'd0;
    assign w_is_clo = 1'b0;
    assign w_is_chi = 1'b0;
`endif

    assign w_mapped = w_is_ram | w_is_data | w_is_stat | w_is_clo | w_is_chi;
    assign w_efault = (ram_load & ram_store) | ((ram_load | ram_store) & ~w_mapped);
    assign w_ld_ok  = ram_load  & ~w_efault;
    assign w_st_ok  = ram_store & ~w_efault;

    // Console FIFO handshake; a pop frees a slot for a same-cycle push
    assign tx_valid  = (r_count != '0);
    assign w_full    = (r_count == c_FULL_CNT);
    assign w_pop     = tx_valid & tx_ready;
    assign w_push    = w_st_ok & w_is_data;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign tx_data   = tx_valid ? r_fifo[r_rptr] : 8'h00;

    assign w_cnt4   = 4'(r_count);
    assign w_status = {24'h0, w_cnt4, 1'b0, r_ovf, w_full, ~tx_valid};

    // Read-data mux; zero unless a legal load is in progress
    always_comb begin
        w_rdata = 32'h0;
        if (w_ld_ok) begin
            if (w_is_ram) begin
                w_rdata = r_ram[ram_address[AW-1:0]];
            end else if (w_is_stat) begin
                w_rdata = w_status;
            end else if (w_is_clo) begin
                w_rdata = w_cycle[31:0];
            end else if (w_is_chi) begin
                w_rdata = w_cycle[63:32];
            end
        end
    end

    assign ram_load_value = w_rdata;
    assign efault         = w_efault;

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clock) begin
        if (w_st_ok && w_is_ram) begin
            r_ram[ram_address[AW-1:0]] <= ram_store_value;
        end
    end

    // FIFO storage; entries are only visible through tx_data when valid
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_fifo[r_wptr] <= ram_store_value[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - (PW+1)'(1);
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (w_st_ok && w_is_stat && ram_store_value[2]) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_ram_responder
// Description : Self-checking bench for rv_ram_responder: directed scenarios
//               followed by randomized traffic compared against a
//               behavioural model (queue FIFO, associative RAM, counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_ram_responder;

    localparam int DEPTH = 1024;
    localparam int FD    = 4;

    localparam logic [29:0] A_DATA = 30'h3FFF_FFC0;
    localparam logic [29:0] A_STAT = 30'h3FFF_FFC1;
    localparam logic [29:0] A_CLO  = 30'h3FFF_FFC2;
    localparam logic [29:0] A_CHI  = 30'h3FFF_FFC3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ram_load = 1'b0;
    logic        ram_store = 1'b0;
    logic [2:0]  ram_funct3 = 3'b010;
    logic [29:0] ram_address = '0;
    logic [31:0] ram_store_value = '0;
    logic [31:0] ram_load_value;
    logic        efault;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    rv_ram_responder #(
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ram_load        (ram_load),
        .ram_store       (ram_store),
        .ram_funct3      (ram_funct3),
        .ram_address     (ram_address),
        .ram_store_value (ram_store_value),
        .ram_load_value  (ram_load_value),
        .efault          (efault),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready)
    );

    always #5 clock = ~clock;

    // Reference model state
    int unsigned     vectors    = 0;
    int unsigned     miscompares = 0;
    logic [31:0]     mram [int];
    logic [7:0]      q [$];
    bit              ovf = 1'b0;
    longint unsigned cyc = 0;
    logic [31:0]     obs_lv;
    logic            obs_ef;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mstatus();
        logic [31:0] s;
        logic [31:0] n;
        n    = q.size();
        s    = '0;
        s[0] = (n == 0);
        s[1] = (n == FD);
        s[2] = ovf;
        s[7:4] = n[3:0];
        return s;
    endfunction

    task automatic req(input bit ld, input bit st, input logic [29:0] a, input logic [31:0] v);
        ram_load        = ld;
        ram_store       = st;
        ram_address     = a;
        ram_store_value = v;
    endtask

    // One clock: predict, check before the edge, then advance the model
    task automatic cycle();
        bit          is_ram, mapped, ef, lv_known, pop, ok_st, cyc_en;
        logic [31:0] lv;
`ifdef RV_RAM_RESPONDER_CYCLE_EN
        cyc_en = 1'b1;
`else
        cyc_en = 1'b0;
`endif
        is_ram   = (ram_address < DEPTH);
        mapped   = is_ram || ram_address == A_DATA || ram_address == A_STAT ||
                   (cyc_en && (ram_address == A_CLO || ram_address == A_CHI));
        ef       = (ram_load && ram_store) || ((ram_load || ram_store) && !mapped);
        lv       = 32'h0;
        lv_known = 1'b1;
        if (ram_load && !ef) begin
            if (is_ram) begin
                if (mram.exists(int'(ram_address))) lv = mram[int'(ram_address)];
                else lv_known = 1'b0;
            end else if (ram_address == A_STAT) lv = mstatus();
            else if (ram_address == A_CLO) lv = cyc[31:0];
            else if (ram_address == A_CHI) lv = cyc[63:32];
        end
        @(negedge clock);
        obs_lv = ram_load_value;
        obs_ef = efault;
        chk("efault", {31'h0, efault}, {31'h0, ef});
        if (lv_known) chk("load_value", ram_load_value, lv);
        chk("tx_valid", {31'h0, tx_valid}, {31'h0, (q.size() != 0)});
        chk("tx_data", {24'h0, tx_data}, {24'h0, (q.size() != 0) ? q[0] : 8'h00});
        ok_st = ram_store && !ef;
        pop   = (q.size() != 0) && tx_ready;
        @(posedge clock);
        if (reset) begin
            if (pop) void'(q.pop_front());
            if (ok_st && ram_address == A_DATA) begin
                if (q.size() < FD) q.push_back(ram_store_value[7:0]);
                else ovf = 1'b1;
            end
            if (ok_st && ram_address == A_STAT && ram_store_value[2]) ovf = 1'b0;
            if (ok_st && is_ram) mram[int'(ram_address)] = ram_store_value;
            if (cyc_en) cyc++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req(0, 0, '0, '0);
            cycle();
        end
    endtask

    initial begin
        // Reset state
        #1;
        req(1, 0, A_STAT, 0);
        cycle();
        chk("reset_status", obs_lv, 32'h0000_0001);
        reset = 1'b1;

        // Cycle counter 10 cycles after release
        idle(10);
        req(1, 0, A_CLO, 0);
        cycle();
`ifdef RV_RAM_RESPONDER_CYCLE_EN
        chk("cycle_lo_10", obs_lv, 32'd10);
`else
        chk("cycle_lo_unmapped", {31'h0, obs_ef}, 32'h1);
`endif

        // RAM store then load; simultaneous load+store faults
        req(0, 1, 30'h10, 32'hDEAD_BEEF);
        cycle();
        req(1, 0, 30'h10, 0);
        cycle();
        chk("ram_readback", obs_lv, 32'hDEAD_BEEF);
        req(1, 1, 30'h10, 32'h1234_5678);
        cycle();
        chk("ld_st_fault", {31'h0, obs_ef}, 32'h1);
        req(1, 0, 30'h10, 0);
        cycle();
        chk("ram_unchanged", obs_lv, 32'hDEAD_BEEF);

        // Overflow: five pushes into a four-entry FIFO with sink stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req(0, 1, A_DATA, 32'h41 + i);
            cycle();
        end
        req(1, 0, A_STAT, 0);
        cycle();
        chk("status_ovf_full", obs_lv, 32'h0000_0046);
        tx_ready = 1'b1;
        idle(5);

        // Clear overflow
        req(0, 1, A_STAT, 32'h4);
        cycle();
        req(1, 0, A_STAT, 0);
        cycle();
        chk("status_cleared", obs_lv, 32'h0000_0001);

        // Full FIFO with simultaneous pop and push
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(0, 1, A_DATA, 32'h61 + i);
            cycle();
        end
        tx_ready = 1'b1;
        req(0, 1, A_DATA, 32'h55);
        cycle();
        tx_ready = 1'b0;
        req(1, 0, A_STAT, 0);
        cycle();
        chk("status_pop_push", obs_lv, 32'h0000_0042);
        tx_ready = 1'b1;
        idle(5);

        // Unmapped addresses
        req(1, 0, 30'h0800_0000, 0);
        cycle();
        chk("unmapped_ram_hi", {31'h0, obs_ef}, 32'h1);
        req(1, 0, 30'h3FFF_FFC4, 0);
        cycle();
        chk("unmapped_mmio", {31'h0, obs_ef}, 32'h1);

        // Asynchronous reset mid-drain
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(0, 1, A_DATA, 32'h70 + i);
            cycle();
        end
        tx_ready = 1'b1;
        idle(1);
        reset = 1'b0;
        #1;
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        q.delete();
        ovf = 1'b0;
        cyc = 0;
        req(1, 0, A_STAT, 0);
        cycle();
        chk("reset_mid_status", obs_lv, 32'h0000_0001);
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 16; i++) begin
            req(0, 1, 30'(i), $urandom);
            cycle();
        end
        for (int i = 0; i < 400; i++) begin
            int op;
            op       = $urandom_range(0, 10);
            tx_ready = ($urandom_range(0, 2) == 0);
            case (op)
                0:       req(0, 0, 30'($urandom), $urandom);
                1:       req(0, 1, 30'($urandom_range(0, 15)), $urandom);
                2:       req(1, 0, 30'($urandom_range(0, 15)), 0);
                3, 4:    req(0, 1, A_DATA, $urandom);
                5:       req(1, 0, A_STAT, 0);
                6:       req(0, 1, A_STAT, $urandom);
                7:       req(1, 0, ($urandom_range(0, 1) != 0) ? A_CLO : A_CHI, 0);
                8:       req(0, 1, ($urandom_range(0, 1) != 0) ? A_CLO : A_CHI, $urandom);
                9:       req(1, 0, 30'h0800_0000 + 30'($urandom_range(0, 255)), 0);
                default: req(1, 1, 30'($urandom_range(0, 15)), $urandom);
            endcase
            cycle();
        end
        tx_ready = 1'b1;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
